dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_if.sv | 22 ++
 rtl/dmem_resp.sv | 108 ++++++++++
 tb/tb_dmem_resp.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// MEM-stage to data-memory responder bus: request fields from the pipeline, then read data and stall/done/err status back.
interface dmem_resp_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_rdata_o, stall_o, done_o, err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_rdata_o, stall_o, done_o, err_o
  );
endinterface

// File: rtl/dmem_resp.sv
// Wait-stated data array for the MEM stage: a request accepted in cycle 0 completes in cycle WAIT_CYCLES+1, and stall_o holds the pipeline until then.
// Define DMEM_ALIGN_CHK_EN to reject unaligned byte-lane patterns (err_o); otherwise any lane pattern is written lane-wise.
module dmem_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic       clk,
  input  logic       rst,
  dmem_resp_if.slave bus
);

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [2:0]            cnt;
  req_t                  req;
  logic [31:0]           rdata;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  access;
  logic                  in_range;
  logic                  sel_ok;

  assign idx      = req.addr[DEPTH_LOG2+1:2];
  assign access   = (state == BUSY) && (cnt == 3'd1);
  assign in_range = (req.addr >> (DEPTH_LOG2 + 2)) == 32'd0;

`ifdef DMEM_ALIGN_CHK_EN
  logic err_q;

  function automatic logic legal_sel(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  assign sel_ok = legal_sel(req.sel);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (access)
      err_q <= !sel_ok;
  end

  assign bus.err_o = (state == DONE) && err_q;
`else
  assign sel_ok    = 1'b1;
  assign bus.err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      req   <= '0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_ce_i) begin
            req   <= '{we: bus.mem_we_i, sel: bus.mem_sel_i,
                       addr: bus.mem_addr_i, data: bus.mem_data_i};
            cnt   <= WAIT_LD;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= DONE;
            if (!req.we)
              rdata <= (in_range && sel_ok) ? mem[idx] : 32'd0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a write still pending when rst arrives is dropped by the !rst gate.
  always_ff @(posedge clk) begin
    if (!rst && access && req.we && in_range && sel_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (req.sel[b])
          mem[idx][8*b +: 8] <= req.data[8*b +: 8];
      end
    end
  end

  assign bus.mem_rdata_o = rdata;
  assign bus.stall_o     = !rst && (((state == IDLE) && bus.mem_ce_i) || (state == BUSY));
  assign bus.done_o      = (state == DONE) && !rst;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed-vector scoreboard bench for dmem_resp: expected completions are queued at issue and checked by a done_o monitor.
module tb_dmem_resp;
  localparam int WAIT = 2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   done_cyc[$];

  dmem_resp_if mif ();

  dmem_resp #(.WAIT_CYCLES(WAIT), .DEPTH_LOG2(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completion pops one expected response.
  always @(negedge clk) begin
    if (!rst && mif.done_o === 1'b1) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done_o high at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata", mif.mem_rdata_o, e.rd);
        check("err", 32'(mif.err_o), 32'(e.err));
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    exp_q.push_back('{rd: exp_rd, err: exp_err});
    @(posedge clk); #1;
    mif.mem_ce_i   = 1'b1;
    mif.mem_we_i   = we;
    mif.mem_sel_i  = sel;
    mif.mem_addr_i = addr;
    mif.mem_data_i = data;
    n = 0;
    @(negedge clk);
    while (mif.stall_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("stall_cycles", 32'(n), 32'(WAIT + 1));
    check("done_at_latency", 32'(mif.done_o), 32'd1);
    @(posedge clk); #1;
    mif.mem_ce_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base;
    mif.mem_ce_i   = 1'b1;
    mif.mem_we_i   = 1'b0;
    mif.mem_sel_i  = 4'hF;
    mif.mem_addr_i = 32'h0;
    mif.mem_data_i = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(mif.stall_o), 32'd0);
    check("rst_done", 32'(mif.done_o), 32'd0);
    check("rst_err", 32'(mif.err_o), 32'd0);
    check("rst_rdata", mif.mem_rdata_o, 32'h0);
    @(posedge clk); #1;
    mif.mem_ce_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(mif.stall_o), 32'd0);

    issue(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 4'b1111, 32'h20, 32'h11223344, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 4'b0100, 32'h22, 32'h00AA0000, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 4'b1111, 32'h20, 32'h0, 32'h11AA3344, 1'b0);
    issue(1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h11AA3344, 1'b0);
    issue(1'b0, 4'b1111, 32'h20, 32'h0, 32'h11AA3344, 1'b0);
    issue(1'b0, 4'b1111, 32'h00100000, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 4'b1111, 32'h00100010, 32'h12345678, 32'h0, 1'b0);
    issue(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 4'b1111, 32'h30, 32'h00000005, 32'hDEADBEEF, 1'b0);

    // Reset lands in the last BUSY cycle, right before the array write edge.
    @(posedge clk); #1;
    mif.mem_ce_i   = 1'b1;
    mif.mem_we_i   = 1'b1;
    mif.mem_sel_i  = 4'hF;
    mif.mem_addr_i = 32'h30;
    mif.mem_data_i = 32'hFFFFFFFF;
    repeat (WAIT) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy_stall", 32'(mif.stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mif.mem_ce_i = 1'b0;
    @(negedge clk);
    check("post_rst_stall", 32'(mif.stall_o), 32'd0);
    check("post_rst_done", 32'(mif.done_o), 32'd0);
    check("post_rst_rdata", mif.mem_rdata_o, 32'h0);
    repeat (4) @(posedge clk);
    issue(1'b0, 4'b1111, 32'h30, 32'h0, 32'h00000005, 1'b0);

    issue(1'b1, 4'b1111, 32'h40, 32'h44332211, 32'h00000005, 1'b0);
`ifdef DMEM_ALIGN_CHK_EN
    issue(1'b1, 4'b0110, 32'h40, 32'hAABBCCDD, 32'h00000005, 1'b1);
    issue(1'b0, 4'b1111, 32'h40, 32'h0, 32'h44332211, 1'b0);
`else
    issue(1'b1, 4'b0110, 32'h40, 32'hAABBCCDD, 32'h00000005, 1'b0);
    issue(1'b0, 4'b1111, 32'h40, 32'h0, 32'h44BBCC11, 1'b0);
`endif

    // Back-to-back reads with mem_ce_i held high.
    base = done_cyc.size();
    exp_q.push_back('{rd: 32'hDEADBEEF, err: 1'b0});
    exp_q.push_back('{rd: 32'hDEADBEEF, err: 1'b0});
    @(posedge clk); #1;
    mif.mem_ce_i   = 1'b1;
    mif.mem_we_i   = 1'b0;
    mif.mem_sel_i  = 4'hF;
    mif.mem_addr_i = 32'h10;
    n = 0;
    while (done_cyc.size() < base + 2 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    mif.mem_ce_i = 1'b0;
    repeat (6) @(posedge clk);
    check("b2b_done_count", 32'(done_cyc.size() - base), 32'd2);
    if (done_cyc.size() >= base + 2)
      check("b2b_spacing", 32'(done_cyc[base+1] - done_cyc[base]), 32'(WAIT + 2));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
